// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: ALU op codes, opcodes and the ID/EX bubble entry.
package riscv_pkg;

    localparam int unsigned ALU_OP_W = 6;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 6'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 6'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 6'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 6'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND   = 6'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL   = 6'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL   = 6'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA   = 6'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = 6'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 6'd9;
    localparam logic [ALU_OP_W-1:0] ALU_ADDI  = 6'd10;
    localparam logic [ALU_OP_W-1:0] ALU_XORI  = 6'd11;
    localparam logic [ALU_OP_W-1:0] ALU_ORI   = 6'd12;
    localparam logic [ALU_OP_W-1:0] ALU_ANDI  = 6'd13;
    localparam logic [ALU_OP_W-1:0] ALU_SLLI  = 6'd14;
    localparam logic [ALU_OP_W-1:0] ALU_SRLI  = 6'd15;
    localparam logic [ALU_OP_W-1:0] ALU_SRAI  = 6'd16;
    localparam logic [ALU_OP_W-1:0] ALU_SLTI  = 6'd17;
    localparam logic [ALU_OP_W-1:0] ALU_SLTIU = 6'd18;
    localparam logic [ALU_OP_W-1:0] ALU_AUIPC = 6'd19;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [31:0]         imm;
        logic                use_imm;
        logic                reg_write;
        logic                branch;
        logic                branch_ne;
        logic [31:0]         pc;
        logic                valid;
        logic                illegal;
    } idex_t;

    localparam logic [ALU_OP_W-1:0] NOP_ALU_OP  = ALU_ADDI;
    localparam logic                NOP_USE_IMM = 1'b1;

    localparam idex_t NOP_ENTRY = '{
        alu_op:    NOP_ALU_OP,
        rs1:       5'd0,
        rs2:       5'd0,
        rd:        5'd0,
        imm:       32'd0,
        use_imm:   NOP_USE_IMM,
        reg_write: 1'b0,
        branch:    1'b0,
        branch_ne: 1'b0,
        pc:        32'd0,
        valid:     1'b0,
        illegal:   1'b0
    };

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: picks the I, B or U immediate from the opcode.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    logic [6:0]  opcode;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;

    assign opcode = instr_i[6:0];
    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_b  = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};

    always_comb begin
        imm_o = 32'd0;
        case (opcode)
            OPC_OP_IMM:         imm_o = imm_i;
            OPC_BRANCH:         imm_o = imm_b;
            OPC_LUI, OPC_AUIPC: imm_o = imm_u;
            default:            imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage feeding the ALU; results held in an ID/EX register with
// flush > stall > load priority and a saturating illegal-instruction counter.
module alu_decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned OP_W  = 6,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic [31:0]      pc_in,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [OP_W-1:0]  alu_op,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic [31:0]      imm_out,
    output logic             use_imm,
    output logic             reg_write,
    output logic             branch,
    output logic             branch_ne,
    output logic [31:0]      pc_out,
    output logic             valid_out,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_raw;

    idex_t            dec;
    logic             dec_illegal;
    idex_t            dec_entry;
    idex_t            entry_d, entry_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    imm_gen u_imm_gen (
        .instr_i (instr_in),
        .imm_o   (imm_raw)
    );

    always_comb begin
        dec             = NOP_ENTRY;
        dec_illegal     = 1'b0;
        dec.valid       = 1'b1;
        dec.pc          = pc_in;
        dec.rs1         = instr_in[19:15];
        dec.rd          = instr_in[11:7];
        dec.imm         = imm_raw;
        case (opcode)
            OPC_OP: begin
                dec.rs2       = instr_in[24:20];
                dec.use_imm   = 1'b0;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec.alu_op = ALU_SLL;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b101:  dec.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec.alu_op = ALU_OR;
                    default: dec.alu_op = ALU_AND;
                endcase
                // The alternate funct7 only distinguishes SUB and SRA.
                if (funct7 == F7_ALT) begin
                    dec_illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
                end else if (funct7 != F7_ZERO) begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_ADDI;
                    3'b001:  dec.alu_op = ALU_SLLI;
                    3'b010:  dec.alu_op = ALU_SLTI;
                    3'b011:  dec.alu_op = ALU_SLTIU;
                    3'b100:  dec.alu_op = ALU_XORI;
                    3'b101:  dec.alu_op = funct7[5] ? ALU_SRAI : ALU_SRLI;
                    3'b110:  dec.alu_op = ALU_ORI;
                    default: dec.alu_op = ALU_ANDI;
                endcase
                if (funct3 == 3'b001) begin
                    dec.imm     = {27'd0, instr_in[24:20]};
                    dec_illegal = (funct7 != F7_ZERO);
                end else if (funct3 == 3'b101) begin
                    dec.imm     = {27'd0, instr_in[24:20]};
                    dec_illegal = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
                end
            end
            OPC_LUI: begin
                dec.alu_op    = ALU_ADDI;
                dec.rs1       = 5'd0;
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op    = ALU_AUIPC;
                dec.rs1       = 5'd0;
                dec.use_imm   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec.rs2       = instr_in[24:20];
                dec.rd        = 5'd0;
                dec.alu_op    = ALU_SUB;
                dec.use_imm   = 1'b0;
                dec.reg_write = 1'b0;
                dec.branch    = 1'b1;
                dec.branch_ne = (funct3 == 3'b001);
                dec_illegal   = (funct3 != 3'b000) && (funct3 != 3'b001);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_entry = dec;
        if (dec_illegal) begin
            dec_entry         = NOP_ENTRY;
            dec_entry.valid   = 1'b1;
            dec_entry.illegal = 1'b1;
        end
    end

    always_comb begin
        entry_d = entry_q;
        cnt_d   = cnt_q;
        if (flush) begin
            entry_d = NOP_ENTRY;
        end else if (stall) begin
            entry_d = entry_q;
        end else if (instr_valid) begin
            entry_d = dec_entry;
            if (dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            entry_d = NOP_ENTRY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry_q <= NOP_ENTRY;
            cnt_q   <= '0;
        end else begin
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alu_op        = OP_W'(entry_q.alu_op);
    assign rs1_addr      = entry_q.rs1;
    assign rs2_addr      = entry_q.rs2;
    assign rd_addr       = entry_q.rd;
    assign imm_out       = entry_q.imm;
    assign use_imm       = entry_q.use_imm;
    assign reg_write     = entry_q.reg_write;
    assign branch        = entry_q.branch;
    assign branch_ne     = entry_q.branch_ne;
    assign pc_out        = entry_q.pc;
    assign valid_out     = entry_q.valid;
    assign illegal       = entry_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: expected entries are queued as stimulus is
// driven and popped when the registered outputs are sampled.
module tb_alu_decode_stage;

    logic        clock;
    logic        reset;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic [5:0]  alu_op;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] imm_out;
    logic        use_imm, reg_write, branch, branch_ne;
    logic [31:0] pc_out;
    logic        valid_out, illegal;
    logic [7:0]  illegal_count;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic        reg_write;
        logic        branch;
        logic        branch_ne;
        logic [31:0] pc;
        logic        valid;
        logic        illegal;
        logic [7:0]  cnt;
    } obs_t;

    obs_t  sb_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    alu_decode_stage #(.OP_W(6), .CNT_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_in      (instr_in),
        .pc_in         (pc_in),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .flush         (flush),
        .alu_op        (alu_op),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rd_addr       (rd_addr),
        .imm_out       (imm_out),
        .use_imm       (use_imm),
        .reg_write     (reg_write),
        .branch        (branch),
        .branch_ne     (branch_ne),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic obs_t mk(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm, input logic ui,
                                input logic rw, input logic br, input logic bne,
                                input logic [31:0] pc, input logic v, input logic il,
                                input logic [7:0] cnt);
        obs_t e;
        e = '{op: op, rs1: rs1, rs2: rs2, rd: rd, imm: imm, use_imm: ui, reg_write: rw,
              branch: br, branch_ne: bne, pc: pc, valid: v, illegal: il, cnt: cnt};
        return e;
    endfunction

    function automatic obs_t nop(input logic [7:0] cnt);
        return mk(6'd10, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, cnt);
    endfunction

    function automatic obs_t ill(input logic [7:0] cnt);
        return mk(6'd10, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, cnt);
    endfunction

    task automatic check();
        obs_t  o, e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o = '{op: alu_op, rs1: rs1_addr, rs2: rs2_addr, rd: rd_addr, imm: imm_out,
              use_imm: use_imm, reg_write: reg_write, branch: branch, branch_ne: branch_ne,
              pc: pc_out, valid: valid_out, illegal: illegal, cnt: illegal_count};
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", t, o, e);
        end
    endtask

    task automatic expect_now(input obs_t e, input string tag);
        sb_q.push_back(e);
        tag_q.push_back(tag);
        check();
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                        input logic s, input logic f, input obs_t e, input string tag);
        instr_in    = ins;
        pc_in       = pc;
        instr_valid = v;
        stall       = s;
        flush       = f;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clock);
        #1;
        check();
    endtask

    obs_t e_held;

    initial begin
        reset       = 1'b1;
        instr_in    = 32'd0;
        pc_in       = 32'd0;
        instr_valid = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        expect_now(nop(8'd0), "reset");
        reset = 1'b0;

        step(32'h002081B3, 32'h40, 1, 0, 0,
             mk(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0, 1, 0, 0, 32'h40, 1, 0, 8'd0), "add");
        step(32'h40208233, 32'h44, 1, 0, 0,
             mk(6'd1, 5'd1, 5'd2, 5'd4, 32'd0, 0, 1, 0, 0, 32'h44, 1, 0, 8'd0), "sub");
        step(32'hFFF00093, 32'h48, 1, 0, 0,
             mk(6'd10, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 1, 1, 0, 0, 32'h48, 1, 0, 8'd0), "addi");
        step(32'h00001117, 32'h100, 1, 0, 0,
             mk(6'd19, 5'd0, 5'd0, 5'd2, 32'h00001000, 1, 1, 0, 0, 32'h100, 1, 0, 8'd0), "auipc");
        step(32'h40335293, 32'h104, 1, 0, 0,
             mk(6'd16, 5'd6, 5'd0, 5'd5, 32'd3, 1, 1, 0, 0, 32'h104, 1, 0, 8'd0), "srai");
        step(32'h123453B7, 32'h108, 1, 0, 0,
             mk(6'd10, 5'd0, 5'd0, 5'd7, 32'h12345000, 1, 1, 0, 0, 32'h108, 1, 0, 8'd0), "lui");
        step(32'h002081B3, 32'h10C, 0, 0, 0, nop(8'd0), "idle");

        e_held = mk(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0, 1, 0, 0, 32'h20, 1, 0, 8'd0);
        step(32'h002081B3, 32'h20, 1, 0, 0, e_held, "accept");
        for (int i = 0; i < 3; i++) begin
            step(32'h40208233 + 32'(i << 7), 32'h24 + 32'(4 * i), 1, 1, 0, e_held, "stall_hold");
        end
        step(32'h40208233, 32'h30, 1, 1, 1, nop(8'd0), "flush_stall");

        step(32'h00000000, 32'h34, 1, 0, 1, nop(8'd0), "flush_illegal");
        step(32'h02208233, 32'h38, 1, 0, 0, ill(8'd1), "bad_funct7");
        step(32'h00000000, 32'h3C, 1, 1, 0, ill(8'd1), "stall_cnt_hold");
        for (int i = 0; i < 300; i++) begin
            step(32'h00000000, 32'h1000, 1, 0, 0, ill((i + 2 > 255) ? 8'd255 : 8'(i + 2)),
                 "illegal_run");
        end

        step(32'h00208463, 32'h200, 1, 0, 0,
             mk(6'd1, 5'd1, 5'd2, 5'd0, 32'd8, 0, 0, 1, 0, 32'h200, 1, 0, 8'd255), "beq");
        step(32'h00209463, 32'h204, 1, 0, 0,
             mk(6'd1, 5'd1, 5'd2, 5'd0, 32'd8, 0, 0, 1, 1, 32'h204, 1, 0, 8'd255), "bne");

        #2;
        reset = 1'b1;
        #1;
        expect_now(nop(8'd0), "async_reset");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        step(32'h002081B3, 32'h300, 0, 0, 0, nop(8'd0), "post_reset_idle");
        step(32'h002081B3, 32'h304, 1, 0, 0,
             mk(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0, 1, 0, 0, 32'h304, 1, 0, 8'd0), "post_reset_add");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered instruction-decode stage that feeds the ALU. It takes a fetched 32-bit RV32I instruction and its PC, then decodes opcode, funct3 and funct7 into the 6-bit `alu_op` encoding the ALU consumes. It also produces register addresses, the immediate and the control flags. Outputs are held in an ID/EX pipeline register with valid, stall and flush control.

## Interface
- `OP_W`, 6: width of `alu_op`; must match the ALU.
- `CNT_W`, 8: width of the saturating illegal-instruction counter.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `instr_in`  in  32: fetched instruction.
- `pc_in`  in  32: PC of `instr_in`.
- `instr_valid`  in  1: `instr_in`/`pc_in` are valid this cycle.
- `stall`  in  1: hold the pipeline register unchanged.
- `flush`  in  1: replace the register contents with a bubble.
- `alu_op`  out  OP_W: ALU operation code.
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5 each: register indices.
- `imm_out`  out  32: sign-extended immediate (I/B/U format).
- `use_imm`  out  1: ALU operand 2 comes from `imm_out`.
- `reg_write`  out  1: write `rd_addr` at writeback.
- `branch`, `branch_ne`  out  1 each: BEQ / BNE decoded.
- `pc_out`  out  32: registered PC.
- `valid_out`  out  1: the register holds a real instruction.
- `illegal`  out  1: the current register entry was an unsupported encoding.
- `illegal_count`  out  CNT_W: saturating count of illegal instructions accepted.

## Operation
- `alu_op` encoding:
  - 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 10 ADDI, 11 XORI, 12 ORI, 13 ANDI, 14 SLLI, 15 SRLI, 16 SRAI, 17 SLTI, 18 SLTIU, 19 AUIPC (pc + operand 2).
- OP (0110011):
  - Selected by funct3 plus funct7[5]: ADD/SUB and SRL/SRA.
  - funct7 values other than 0000000/0100000 are illegal.
  - `use_imm`=0, `reg_write`=1.
- OP-IMM (0010011):
  - I-type immediate, `use_imm`=1, `reg_write`=1.
  - SLLI requires funct7=0000000. SRLI/SRAI are selected by funct7[5]; other funct7 values are illegal.
  - `imm_out` carries the full sign-extended I immediate. For shifts, the ALU sees bits [4:0] only when upper bits are zero, so the stage zeroes `imm_out[31:5]` for shifts.
- LUI (0110111): `alu_op`=10, `rs1_addr`=0, `imm_out`={instr[31:12],12'b0}, `use_imm`=1.
- AUIPC (0010111): `alu_op`=19, U immediate, `use_imm`=1, `rs1_addr`=0.
- BRANCH (1100011):
  - funct3 000 gives `branch`=1; funct3 001 gives `branch`=1 and `branch_ne`=1.
  - `alu_op`=1, `use_imm`=0, `reg_write`=0, `imm_out` = B immediate. The zero flag drives the branch decision downstream.
  - Other funct3 values are illegal.
- Any other opcode is illegal.
- Illegal entries load as a bubble with `illegal`=1 and `valid_out`=1. `illegal_count` increments by 1, saturating at all-ones.
- Bubble (NOP) value:
  - `alu_op`=10, all addresses 0, `imm_out`=0, `use_imm`=1.
  - `reg_write`=0, `branch`=0, `branch_ne`=0, `illegal`=0, `valid_out`=0, `pc_out`=0.

## Timing
- Reset (asynchronous): all outputs take the bubble value and `illegal_count`=0. Reset asserted mid-stream discards the held entry immediately.
- Latency: the decoded fields appear on outputs the cycle after the edge that samples `instr_valid`=1.
- The ALU registers its result, so the result is available two edges after acceptance.
- Per-edge priority: `flush` > `stall` > load.
  - `flush`=1: load the bubble regardless of `stall`/`instr_valid`; the counter does not increment.
  - `stall`=1 (no flush): all registers, including the counter, hold.
  - Otherwise, with `instr_valid`=1: load the decoded instruction.
  - Otherwise, with `instr_valid`=0: load the bubble.
- All outputs come directly from registers; there is no combinational path from input to output.

## Structure
- Package `riscv_pkg`:
  - the `alu_op` localparams (ALU_ADD … ALU_AUIPC);
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH);
  - the NOP field values.
- Sub-module `imm_gen`: combinational, instruction → I/B/U immediate by opcode. Everything else lives in the stage.

## Test plan
- Reset then 0x002081B3 (add x3,x1,x2), valid → next cycle `alu_op`=0, rs1=1, rs2=2, rd=3, `reg_write`=1, `valid_out`=1.
- 0x40208233 (sub x4,x1,x2) → `alu_op`=1. 0xFFF00093 (addi x1,x0,-1) → `alu_op`=10, `imm_out`=0xFFFFFFFF, `use_imm`=1.
- 0x00001117 (auipc x2,1) at `pc_in`=0x100 → `alu_op`=19, `imm_out`=0x00001000, `pc_out`=0x100.
- Instruction accepted, then `stall`=1 for 3 cycles with new inputs → outputs unchanged. Then `flush`=1 with `stall`=1 → bubble, `valid_out`=0.
- 0x00000000 (illegal) repeated 300 times → `illegal`=1 on each, `illegal_count` saturates at 255. A flushed illegal entry does not count.
- 0x00208463 (beq x1,x2,8) → `branch`=1, `branch_ne`=0, `alu_op`=1, `imm_out`=8. Assert `reset` mid-sequence → outputs return to the bubble value without waiting for a clock edge.
